seg_scan_mux: RTL and testbench

Time-multiplexed seven-segment scanner placed directly downstream of the digital-clock datapath. Consumes the six packed 8-bit segment patterns (48 bits, digit 0 in bits [7:0]) produced by the per-digit BCD decoders and drives one shared segment bus plus six digit-enable lines. Adds frame-synchronous snapshotting (no tearing), an inter-digit blanking gap (anti-ghosting) and 16-level PWM brightness.

---
 rtl/seg_scan_pkg.sv | 21 ++
 rtl/scan_timer.sv | 52 +++++
 rtl/seg_scan_mux.sv | 68 ++++++
 tb/tb_seg_scan_mux.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_scan_pkg;

   localparam int         NUM_DIGITS = 6;
   localparam logic [7:0] SEG_OFF    = 8'hFF;
   localparam logic [5:0] AN_OFF     = 6'h3F;

   // Slot phase: dark gap first (anti-ghosting), then the PWM-modulated on-phase.
   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_ON    = 1'b1
   } phase_t;

   // Active-low one-hot digit enable for digit d.
   function automatic logic [5:0] an_onehot(input logic [2:0] d);
      return ~(6'b000001 << d);
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot/digit/PWM counters driving the scanner's phase decode.
// Latency: outputs are combinational views of the current counter state.
// Backpressure: en low freezes every counter; frame strobe is gated by en.
module scan_timer
   import seg_scan_pkg::*;
#(
   parameter int DWELL = 50000,
   parameter int BLANK = 1000,
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic [2:0] dig,
   output phase_t     phase,
   output logic [3:0] pwm,
   output logic       frame_strobe
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
   localparam logic [2:0]       DIG_LAST  = 3'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Next slot count and phase/strobe decode of the current state.
   always_comb begin
      cnt_nxt      = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      phase        = (cnt < CNT_BLANK) ? PH_BLANK : PH_ON;
      frame_strobe = en && (cnt == '0) && (dig == 3'd0);
   end

   // Advance slot, digit and PWM counters on enabled cycles only.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
         dig <= 3'd0;
         pwm <= 4'd0;
      end else if (en) begin
         cnt <= cnt_nxt;
         if (cnt == CNT_LAST)
            dig <= (dig == DIG_LAST) ? 3'd0 : dig + 3'd1;
         // pwm reads 0 on the first on-phase cycle, then counts mod 16.
         if (cnt_nxt == CNT_BLANK)
            pwm <= 4'd0;
         else if (phase == PH_ON)
            pwm <= pwm + 4'd1;
      end
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner with frame snapshot, blanking gap and PWM.
// Latency: one cycle from counter state to registered an/seg_out/frame_start.
// Backpressure: en low holds the scan position and blanks all outputs.
module seg_scan_mux
   import seg_scan_pkg::*;
#(
   parameter int DWELL = 50000,
   parameter int BLANK = 1000,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [47:0] seg_in,
   input  logic [3:0]  bright,
   output logic [7:0]  seg_out,
   output logic [5:0]  an,
   output logic        frame_start
);

   logic [2:0]                  dig;
   phase_t                      phase;
   logic [3:0]                  pwm;
   logic                        frame_strobe;
   logic                        lit;
   logic [NUM_DIGITS-1:0][7:0]  snapshot;

   scan_timer #(
      .DWELL (DWELL),
      .BLANK (BLANK),
      .CNT_W (CNT_W)
   ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .dig          (dig),
      .phase        (phase),
      .pwm          (pwm),
      .frame_strobe (frame_strobe)
   );

   // A digit is lit only in its on-phase while the PWM count is within brightness.
   always_comb begin
      lit = en && (phase == PH_ON) && (pwm <= bright);
   end

   // Snapshot at frame start so a frame never mixes old and new patterns; register outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         snapshot    <= '1;
         seg_out     <= SEG_OFF;
         an          <= AN_OFF;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_strobe;
         if (frame_strobe)
            snapshot <= seg_in;
         if (lit) begin
            an      <= an_onehot(dig);
            seg_out <= snapshot[dig];
         end else begin
            an      <= AN_OFF;
            seg_out <= SEG_OFF;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: two instances (short slot, and PWM-sized slot).
// Latency: each tick samples outputs 1 time unit after the rising edge.
// Backpressure: en is driven directly by the scenarios.
module tb_seg_scan_mux;

   logic        clk;
   logic        reset;
   logic        en;
   logic [47:0] seg_in;
   logic [3:0]  bright;
   logic [7:0]  seg_out_a;
   logic [5:0]  an_a;
   logic        fs_a;
   logic [7:0]  seg_out_b;
   logic [5:0]  an_b;
   logic        fs_b;

   int n_cmp = 0;
   int n_bad = 0;

   seg_scan_mux #(.DWELL(8), .BLANK(2), .CNT_W(4)) u_dut_a (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .seg_in      (seg_in),
      .bright      (bright),
      .seg_out     (seg_out_a),
      .an          (an_a),
      .frame_start (fs_a)
   );

   seg_scan_mux #(.DWELL(40), .BLANK(8), .CNT_W(6)) u_dut_b (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .seg_in      (seg_in),
      .bright      (bright),
      .seg_out     (seg_out_b),
      .an          (an_b),
      .frame_start (fs_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset held with en high keeps everything dark; frame_start on first edge after release.
   task automatic test_reset();
      seg_in = 48'h665544332211;
      bright = 4'd15;
      en     = 1'b1;
      reset  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({an_a, seg_out_a, fs_a} !== {6'h3F, 8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hold[%0d]: an=%h seg=%h fs=%b, want an=3f seg=ff fs=0", i, an_a, seg_out_a, fs_a);
         end
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({an_a, seg_out_a, fs_a} !== {6'h3F, 8'hFF, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_release: an=%h seg=%h fs=%b, want an=3f seg=ff fs=1", an_a, seg_out_a, fs_a);
      end
   endtask

   // Full frame at full brightness: 2 blank + 6 lit per slot, frame_start every 48.
   task automatic test_full_scan();
      int k, c;
      logic [5:0] ea;
      logic [7:0] es;
      logic       ef;
      seg_in = 48'h665544332211;
      bright = 4'd15;
      en     = 1'b1;
      reset  = 1'b0;
      tick();
      reset  = 1'b1;
      for (int j = 1; j <= 49; j++) begin
         tick();
         k  = ((j - 1) / 8) % 6;
         c  = (j - 1) % 8;
         ef = (j == 1 || j == 49);
         if (c >= 2) begin
            ea = ~(6'b000001 << k);
            es = 8'((k + 1) * 17);
         end else begin
            ea = 6'h3F;
            es = 8'hFF;
         end
         n_cmp++;
         if ({an_a, seg_out_a, fs_a} !== {ea, es, ef}) begin
            n_bad++;
            $display("FAIL full_scan[%0d]: an=%h seg=%h fs=%b, want an=%h seg=%h fs=%b",
                     j, an_a, seg_out_a, fs_a, ea, es, ef);
         end
      end
   endtask

   // seg_in changes mid-frame; the change shows only from the next frame.
   task automatic test_snapshot();
      int k, c;
      logic [5:0] ea;
      logic [7:0] es;
      seg_in = 48'h665544332211;
      bright = 4'd15;
      en     = 1'b1;
      reset  = 1'b0;
      tick();
      reset  = 1'b1;
      for (int j = 1; j <= 64; j++) begin
         tick();
         if (j == 17) seg_in = 48'h000000000000;
         k = ((j - 1) / 8) % 6;
         c = (j - 1) % 8;
         if (c >= 2) begin
            ea = ~(6'b000001 << k);
            es = (j <= 48) ? 8'((k + 1) * 17) : 8'h00;
         end else begin
            ea = 6'h3F;
            es = 8'hFF;
         end
         n_cmp++;
         if ({an_a, seg_out_a} !== {ea, es}) begin
            n_bad++;
            $display("FAIL snapshot[%0d]: an=%h seg=%h, want an=%h seg=%h", j, an_a, seg_out_a, ea, es);
         end
      end
   endtask

   // PWM on the 40-cycle slot: bright=3 -> 8 lit in 2 runs, bright=0 -> 2 lit.
   task automatic test_brightness();
      int c, k, lit_cnt, runs;
      logic prev_lit, now_lit, exp_lit;
      logic [5:0] ea;
      seg_in = 48'h665544332211;
      bright = 4'd3;
      en     = 1'b1;
      reset  = 1'b0;
      tick();
      reset  = 1'b1;
      lit_cnt  = 0;
      runs     = 0;
      prev_lit = 1'b0;
      for (int j = 1; j <= 80; j++) begin
         tick();
         k = (j - 1) / 40;
         c = (j - 1) % 40;
         exp_lit = (c >= 8) && (((c - 8) % 16) <= ((k == 0) ? 3 : 0));
         ea      = exp_lit ? ~(6'b000001 << k) : 6'h3F;
         n_cmp++;
         if (an_b !== ea) begin
            n_bad++;
            $display("FAIL bright_cycle[%0d]: an=%h, want an=%h", j, an_b, ea);
         end
         now_lit = (an_b != 6'h3F);
         if (now_lit) lit_cnt++;
         if (now_lit && !prev_lit) runs++;
         prev_lit = now_lit;
         if (j == 40) begin
            n_cmp++;
            if (lit_cnt != 8 || runs != 2) begin
               n_bad++;
               $display("FAIL bright3_count: lit=%0d runs=%0d, want lit=8 runs=2", lit_cnt, runs);
            end
            bright  = 4'd0;
            lit_cnt = 0;
            runs    = 0;
         end
      end
      n_cmp++;
      if (lit_cnt != 2) begin
         n_bad++;
         $display("FAIL bright0_count: lit=%0d, want 2", lit_cnt);
      end
   endtask

   // en dropped for 5 cycles at cnt=4 of digit 1: dark while held, then resumes in place.
   task automatic test_enable_hold();
      int lit_cnt;
      logic [5:0] ea;
      logic [7:0] es;
      seg_in = 48'h665544332211;
      bright = 4'd15;
      en     = 1'b1;
      reset  = 1'b0;
      tick();
      reset  = 1'b1;
      for (int j = 1; j <= 12; j++) tick();
      n_cmp++;
      if ({an_a, seg_out_a} !== {6'h3D, 8'h22}) begin
         n_bad++;
         $display("FAIL hold_pre: an=%h seg=%h, want an=3d seg=22", an_a, seg_out_a);
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if ({an_a, seg_out_a, fs_a} !== {6'h3F, 8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_dark[%0d]: an=%h seg=%h fs=%b, want an=3f seg=ff fs=0", i, an_a, seg_out_a, fs_a);
         end
      end
      en = 1'b1;
      lit_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if ({an_a, seg_out_a} === {6'h3D, 8'h22}) lit_cnt++;
      end
      n_cmp++;
      if (lit_cnt != 4) begin
         n_bad++;
         $display("FAIL hold_resume: digit1 lit=%0d, want 4", lit_cnt);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         ea = (c >= 2) ? 6'h3B : 6'h3F;
         es = (c >= 2) ? 8'h33 : 8'hFF;
         n_cmp++;
         if ({an_a, seg_out_a} !== {ea, es}) begin
            n_bad++;
            $display("FAIL hold_next[%0d]: an=%h seg=%h, want an=%h seg=%h", c, an_a, seg_out_a, ea, es);
         end
      end
   endtask

   // One-cycle reset inside digit 4's on-phase restarts at digit 0 with a fresh snapshot.
   task automatic test_mid_reset();
      seg_in = 48'h665544332211;
      bright = 4'd15;
      en     = 1'b1;
      reset  = 1'b0;
      tick();
      reset  = 1'b1;
      for (int j = 1; j <= 35; j++) tick();
      n_cmp++;
      if ({an_a, seg_out_a} !== {6'h2F, 8'h55}) begin
         n_bad++;
         $display("FAIL midrst_pre: an=%h seg=%h, want an=2f seg=55", an_a, seg_out_a);
      end
      reset  = 1'b0;
      seg_in = 48'h0F0E0D0C0B0A;
      tick();
      n_cmp++;
      if ({an_a, seg_out_a, fs_a} !== {6'h3F, 8'hFF, 1'b0}) begin
         n_bad++;
         $display("FAIL midrst_dark: an=%h seg=%h fs=%b, want an=3f seg=ff fs=0", an_a, seg_out_a, fs_a);
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({an_a, seg_out_a, fs_a} !== {6'h3F, 8'hFF, 1'b1}) begin
         n_bad++;
         $display("FAIL midrst_frame: an=%h seg=%h fs=%b, want an=3f seg=ff fs=1", an_a, seg_out_a, fs_a);
      end
      tick();
      tick();
      n_cmp++;
      if ({an_a, seg_out_a, fs_a} !== {6'h3E, 8'h0A, 1'b0}) begin
         n_bad++;
         $display("FAIL midrst_reload: an=%h seg=%h fs=%b, want an=3e seg=0a fs=0", an_a, seg_out_a, fs_a);
      end
   endtask

   initial begin
      reset  = 1'b0;
      en     = 1'b0;
      seg_in = '0;
      bright = '0;
      test_reset();
      test_full_scan();
      test_snapshot();
      test_brightness();
      test_enable_hold();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
